instr_sequencer: RTL and testbench
==================================

# instr_sequencer

Multi-cycle instruction sequencer for the 5-bit-opcode processor. It owns the program counter and steps each instruction through FETCH, DECODE, EXEC, MEM and WB using the control-unit decode outputs. It drives request/acknowledge handshakes to instruction and data memory and issues the single-cycle register-file and flags write strobes. It sits between the memories, the control unit, the register file and the flags register.

## Interface
- PC_WIDTH, 8, program-counter / address width
- RESET_PC, 0, PC value after reset
- TIMEOUT, 15, max cycles to wait for an ack before error (≥2)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- run  in  1  start/continue execution
- im_ack  in  1  instruction memory ack (IR data valid)
- dm_ack  in  1  data memory ack
- reg_write, is_mem_access, dm_write_enable, flags_write  in  1 each  control-unit decode
- is_jz, is_jnz, is_jg, is_jl, is_jump  in  1 each  control-unit branch decode
- zf, gf, lf  in  1 each  registered zero / greater / less flags
- target  in  PC_WIDTH  branch/jump target from IR
- pc  out  PC_WIDTH  program counter (registered)
- im_req  out  1  instruction fetch request
- ir_load  out  1  IR load strobe
- dm_req  out  1  data memory request
- dm_we  out  1  data memory write qualifier
- rf_we  out  1  register-file write strobe
- flags_we  out  1  flags-register write strobe
- retire  out  1  instruction completes this cycle
- instret  out  16  retired-instruction counter (registered, wraps)
- err  out  1  sticky handshake-timeout error (registered)

## Operation
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, ERR. All strobes are decoded from the current state and inputs (combinational). pc, instret, err and the wait counter are registered.
- IDLE: all strobes 0. If run=1, go to FETCH.
- FETCH: im_req=1. The wait counter clears on entry. On im_ack=1: ir_load=1 this cycle, then go to DECODE.
- DECODE: one cycle, no strobes. Control-unit outputs settle from the IR. Go to EXEC.
- EXEC:
  - flags_we = flags_write.
  - take = is_jump | (is_jz&zf) | (is_jnz&~zf) | (is_jg&gf) | (is_jl&lf).
  - If is_mem_access|dm_write_enable, go to MEM.
  - Else if reg_write, go to WB.
  - Else retire here.
- MEM: dm_req=1 and dm_we=dm_write_enable until dm_ack. The wait counter clears on entry. On dm_ack: if dm_write_enable (store), retire here; else go to WB.
- WB: rf_we=1 for one cycle, then retire.
- Retire cycle: retire=1. At the clock edge:
  - pc ← take ? target : pc+1. pc+1 wraps modulo 2^PC_WIDTH. take is latched in EXEC for instructions that retire later.
  - instret ← instret+1.
  - Next state is FETCH if run=1, else IDLE.
- Timeout: in FETCH or MEM, the counter increments each cycle without ack. When it reaches TIMEOUT-1 with no ack, go to ERR and set err=1. If ack arrives in that same cycle, the ack wins.
- ERR: all strobes 0. pc and instret hold. Leaves only via rst_n.
- run deasserted mid-instruction is ignored until the retire cycle.
- Opcodes decoding to no action (NOP, default) retire from EXEC.

## Timing
- Reset (asynchronous, immediate):
  - state=IDLE, pc=RESET_PC, instret=0, err=0, wait counter=0.
  - All strobes 0 while rst_n=0.
  - Reset mid-handshake drops im_req/dm_req at once.
- Latencies, first cycle in FETCH to retire edge, with ack in the first request cycle:
  - NOP/CMP/branches: 3 cycles.
  - ALU/MOV/LI/ADDI: 4 cycles.
  - SW: 4 cycles.
  - LW: 5 cycles.
  - Each extra ack wait cycle adds 1.
- Ack is sampled only while the matching req=1; acks in other states are ignored.
- Flags written in EXEC are visible to the next instruction's EXEC, so a CMP followed by a branch needs no interlock.
- The strobes ir_load, rf_we, flags_we and retire are each exactly one cycle per instruction.

## Test plan
- Reset then run=1, im_ack tied 1, ADD decode (reg_write=1, flags_write=1) → FETCH, DECODE, EXEC (flags_we=1), WB (rf_we=1); pc 0→1 after 4 cycles; instret=1.
- LW (reg_write=1, is_mem_access=1), dm_ack delayed 3 cycles → dm_req high 4 cycles, dm_we=0, then rf_we; retire at cycle 8; pc=1.
- CMP then JZ with zf=1, target=8'h20 → CMP: flags_we=1, no rf_we; JZ retires from EXEC with pc=0x20. Repeat with zf=0 → pc=prev+1.
- pc=8'hFF, NOP retire → pc wraps to 8'h00; instret wraps 16'hFFFF→0.
- im_ack never asserted, TIMEOUT=15 → err=1 after the 15th FETCH cycle; im_req=0 afterwards; pc/instret frozen. Ack arriving exactly on cycle 15 → no error.
- run dropped during MEM of SW → instruction completes (dm_we=1, retire), then IDLE with no further im_req. rst_n pulsed low mid-FETCH → outputs to reset values immediately.

Source files
------------

// File: rtl/instr_sequencer.sv
// Multi-cycle instruction sequencer: owns pc, steps FETCH..WB.
// Ports: run/acks/decode/flags in; pc, req/strobes, instret, err out.
module instr_sequencer #(
  parameter int unsigned PC_WIDTH = 8,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                run,
  input  logic                im_ack,
  input  logic                dm_ack,
  input  logic                reg_write,
  input  logic                is_mem_access,
  input  logic                dm_write_enable,
  input  logic                flags_write,
  input  logic                is_jz,
  input  logic                is_jnz,
  input  logic                is_jg,
  input  logic                is_jl,
  input  logic                is_jump,
  input  logic                zf,
  input  logic                gf,
  input  logic                lf,
  input  logic [PC_WIDTH-1:0] target,
  output logic [PC_WIDTH-1:0] pc,
  output logic                im_req,
  output logic                ir_load,
  output logic                dm_req,
  output logic                dm_we,
  output logic                rf_we,
  output logic                flags_we,
  output logic                retire,
  output logic [15:0]         instret,
  output logic                err
);

  localparam int unsigned CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    EXEC,
    MEM,
    WB,
    ERR
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          take_q;

  logic take;
  logic take_now;
  logic mem_op;
  logic expire;

  always_comb begin
    take   = is_jump
           | (is_jz & zf)
           | (is_jnz & ~zf)
           | (is_jg & gf)
           | (is_jl & lf);
    mem_op = is_mem_access | dm_write_enable;
    expire = (cnt == CNT_MAX);
    // Branch decision is only live in EXEC; later retires use the latch.
    take_now = (state == EXEC) ? take : take_q;
  end

  always_comb begin
    im_req   = 1'b0;
    ir_load  = 1'b0;
    dm_req   = 1'b0;
    dm_we    = 1'b0;
    rf_we    = 1'b0;
    flags_we = 1'b0;
    retire   = 1'b0;
    unique case (state)
      FETCH: begin
        im_req  = 1'b1;
        ir_load = im_ack;
      end
      EXEC: begin
        flags_we = flags_write;
        retire   = ~mem_op & ~reg_write;
      end
      MEM: begin
        dm_req = 1'b1;
        dm_we  = dm_write_enable;
        retire = dm_ack & dm_write_enable;
      end
      WB: begin
        rf_we  = 1'b1;
        retire = 1'b1;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      pc      <= RESET_PC;
      instret <= '0;
      err     <= 1'b0;
      cnt     <= '0;
      take_q  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          cnt <= '0;
          if (run) state <= FETCH;
        end
        FETCH: begin
          if (im_ack) begin
            state <= DECODE;
            cnt   <= '0;
          end else if (expire) begin
            state <= ERR;
            err   <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DECODE: state <= EXEC;
        EXEC: begin
          take_q <= take;
          if (mem_op) begin
            state <= MEM;
            cnt   <= '0;
          end else if (reg_write) begin
            state <= WB;
          end
        end
        MEM: begin
          if (dm_ack) begin
            if (!dm_write_enable) state <= WB;
          end else if (expire) begin
            state <= ERR;
            err   <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
        end
      endcase
      // Retire overrides the per-state next state.
      if (retire) begin
        pc      <= take_now ? target : pc + PC_WIDTH'(1);
        instret <= instret + 16'd1;
        cnt     <= '0;
        state   <= run ? FETCH : IDLE;
      end
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: instruction table plus
// hand-written run-drop, timeout and async-reset sequences.
module tb_instr_sequencer;

  logic       clk;
  logic       rst_n;
  logic       run;
  logic       im_ack;
  logic       dm_ack;
  logic       reg_write;
  logic       is_mem_access;
  logic       dm_write_enable;
  logic       flags_write;
  logic       is_jz;
  logic       is_jnz;
  logic       is_jg;
  logic       is_jl;
  logic       is_jump;
  logic       zf;
  logic       gf;
  logic       lf;
  logic [7:0] target;
  logic [7:0] pc;
  logic       im_req;
  logic       ir_load;
  logic       dm_req;
  logic       dm_we;
  logic       rf_we;
  logic       flags_we;
  logic       retire;
  logic [15:0] instret;
  logic       err;

  instr_sequencer dut (
    .clk(clk),
    .rst_n(rst_n),
    .run(run),
    .im_ack(im_ack),
    .dm_ack(dm_ack),
    .reg_write(reg_write),
    .is_mem_access(is_mem_access),
    .dm_write_enable(dm_write_enable),
    .flags_write(flags_write),
    .is_jz(is_jz),
    .is_jnz(is_jnz),
    .is_jg(is_jg),
    .is_jl(is_jl),
    .is_jump(is_jump),
    .zf(zf),
    .gf(gf),
    .lf(lf),
    .target(target),
    .pc(pc),
    .im_req(im_req),
    .ir_load(ir_load),
    .dm_req(dm_req),
    .dm_we(dm_we),
    .rf_we(rf_we),
    .flags_we(flags_we),
    .retire(retire),
    .instret(instret),
    .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rw, mem, dwe, fw;
    logic       jz, jnz, jg, jl, jmp;
    logic       zf, gf, lf;
    logic [7:0] tgt;
    int         im_d, dm_d;
    int         cyc;
    logic [7:0] pc;
    int         nrf, nfl, ndq, nwe;
  } vec_t;

  vec_t tab[15];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   ni = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic set_dec(input vec_t v);
    reg_write       = v.rw;
    is_mem_access   = v.mem;
    dm_write_enable = v.dwe;
    flags_write     = v.fw;
    is_jz           = v.jz;
    is_jnz          = v.jnz;
    is_jg           = v.jg;
    is_jl           = v.jl;
    is_jump         = v.jmp;
    zf              = v.zf;
    gf              = v.gf;
    lf              = v.lf;
    target          = v.tgt;
  endtask

  task automatic run_vec(input int i, input vec_t v);
    int cyc = 0, ic = 0, dc = 0;
    int nrf = 0, nfl = 0, nir = 0, ndq = 0, nwe = 0;
    bit started = 0, done = 0;
    set_dec(v);
    for (int k = 0; k < 80 && !done; k++) begin
      @(negedge clk);
      im_ack = im_req && (ic == v.im_d);
      dm_ack = dm_req && (dc == v.dm_d);
      #1;
      if (im_req) begin
        started = 1;
        ic++;
      end
      if (dm_req) dc++;
      if (started) begin
        cyc++;
        nrf += int'(rf_we);
        nfl += int'(flags_we);
        nir += int'(ir_load);
        ndq += int'(dm_req);
        nwe += int'(dm_req && dm_we);
        if (retire) done = 1;
      end
    end
    @(posedge clk);
    #1;
    im_ack = 1'b0;
    dm_ack = 1'b0;
    ni++;
    chk($sformatf("v%0d_retired", i), 32'(done), 32'd1);
    chk($sformatf("v%0d_cycles", i), 32'(cyc), 32'(v.cyc));
    chk($sformatf("v%0d_pc", i), 32'(pc), 32'(v.pc));
    chk($sformatf("v%0d_instret", i), 32'(instret), 32'(ni));
    chk($sformatf("v%0d_ir_load", i), 32'(nir), 32'd1);
    chk($sformatf("v%0d_rf_we", i), 32'(nrf), 32'(v.nrf));
    chk($sformatf("v%0d_flags_we", i), 32'(nfl), 32'(v.nfl));
    chk($sformatf("v%0d_dm_req", i), 32'(ndq), 32'(v.ndq));
    chk($sformatf("v%0d_dm_we", i), 32'(nwe), 32'(v.nwe));
  endtask

  initial begin
    vec_t sw;
    int dc, reqc, nreq;
    bit done, seen, we_ret;

    //            rw mem dwe fw jz jnz jg jl jmp zf gf lf tgt    imd dmd cyc pc    rf fl dq we
    tab[0]  = '{1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0, 4,  8'h01, 1, 1, 0, 0};
    tab[1]  = '{1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 3, 8,  8'h02, 1, 0, 4, 0};
    tab[2]  = '{0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0, 3,  8'h03, 0, 1, 0, 0};
    tab[3]  = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 8'h20, 0, 0, 3,  8'h20, 0, 0, 0, 0};
    tab[4]  = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 8'h40, 0, 0, 3,  8'h21, 0, 0, 0, 0};
    tab[5]  = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 8'h30, 0, 0, 3,  8'h30, 0, 0, 0, 0};
    tab[6]  = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 8'h50, 0, 0, 3,  8'h31, 0, 0, 0, 0};
    tab[7]  = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 8'h10, 0, 0, 3,  8'h10, 0, 0, 0, 0};
    tab[8]  = '{0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0, 4,  8'h11, 0, 0, 1, 1};
    tab[9]  = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 8'hFE, 2, 0, 5,  8'hFE, 0, 0, 0, 0};
    tab[10] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h77, 0, 0, 3,  8'hFF, 0, 0, 0, 0};
    tab[11] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h77, 0, 0, 3,  8'h00, 0, 0, 0, 0};
    tab[12] = '{1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 8'h80, 0, 1, 6,  8'h80, 1, 0, 2, 0};
    tab[13] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00, 14, 0, 18, 8'h81, 1, 0, 0, 0};
    tab[14] = '{0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 1, 5,  8'h82, 0, 0, 2, 2};

    rst_n  = 1'b0;
    run    = 1'b0;
    im_ack = 1'b0;
    dm_ack = 1'b0;
    set_dec(tab[10]);
    #12;
    chk("rst_pc", 32'(pc), 32'h0);
    chk("rst_instret", 32'(instret), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_im_req", 32'(im_req), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("idle_no_req", 32'(im_req), 32'h0);
    run = 1'b1;

    for (int i = 0; i < 15; i++) run_vec(i, tab[i]);

    // SW with run dropped while waiting in MEM.
    sw = tab[8];
    set_dec(sw);
    dc = 0;
    done = 0;
    we_ret = 0;
    for (int k = 0; k < 30 && !done; k++) begin
      @(negedge clk);
      im_ack = im_req;
      dm_ack = dm_req && (dc == 2);
      #1;
      if (dm_req) begin
        if (dc == 0) run = 1'b0;
        dc++;
      end
      if (retire) begin
        done = 1;
        we_ret = dm_we;
      end
    end
    @(posedge clk);
    #1;
    im_ack = 1'b0;
    dm_ack = 1'b0;
    ni++;
    chk("drop_retired", 32'(done), 32'd1);
    chk("drop_dm_we", 32'(we_ret), 32'd1);
    chk("drop_pc", 32'(pc), 32'h83);
    chk("drop_instret", 32'(instret), 32'(ni));
    nreq = 0;
    repeat (5) begin
      @(negedge clk);
      nreq += int'(im_req);
    end
    chk("drop_idle_req", 32'(nreq), 32'd0);

    // Fetch that is never acknowledged.
    @(posedge clk);
    #1;
    run = 1'b1;
    reqc = 0;
    seen = 0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      #1;
      if (err) seen = 1;
      else if (im_req) reqc++;
    end
    chk("to_err", 32'(seen), 32'd1);
    chk("to_req_cycles", 32'(reqc), 32'd15);
    chk("to_im_req_off", 32'(im_req), 32'd0);
    repeat (3) @(negedge clk);
    chk("to_err_sticky", 32'(err), 32'd1);
    chk("to_pc_hold", 32'(pc), 32'h83);
    chk("to_instret_hold", 32'(instret), 32'(ni));
    chk("to_req_stays_off", 32'(im_req), 32'd0);

    // Asynchronous reset in the middle of a fetch.
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    repeat (3) @(negedge clk);
    chk("mid_in_fetch", 32'(im_req), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_req", 32'(im_req), 32'd0);
    chk("mid_rst_pc", 32'(pc), 32'h0);
    chk("mid_rst_instret", 32'(instret), 32'h0);
    chk("mid_rst_err", 32'(err), 32'h0);
    #10;
    rst_n = 1'b1;
    run = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
